// File: rtl/prio_arb_pkg.sv
// ============================================================================
// Module  : prio_arb_pkg
// Brief   : Shared types and constants for the 8-way hold-limited arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package prio_arb_pkg;

    localparam int NREQ  = 8;
    localparam int IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    function automatic logic [NREQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
        return {{(NREQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/prio_enc8.sv
// ============================================================================
// Module  : prio_enc8
// Brief   : Combinational 8-to-3 priority encoder, highest set bit wins.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module prio_enc8
    import prio_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             vld_o
);

    // Ascending scan: the last (highest) set bit overwrites lower ones.
    always_comb begin
        idx_o = '0;
        vld_o = |req_i;
        for (int i = 0; i < NREQ; i++) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/prio_arb8.sv
// ============================================================================
// Module  : prio_arb8
// Brief   : 8-requester arbiter with per-owner hold limit and timeout pulse.
//           Define PRIO_ARB8_RR_EN for round-robin selection (default: fixed).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module prio_arb8
    import prio_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             timeout
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       hold_q, hold_d;
    logic             to_q, to_d;

    logic [NREQ-1:0]  enc_in;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_vld;
    logic [IDX_W-1:0] winner;

`ifdef PRIO_ARB8_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Bit-reversed rotation puts req[ptr] at the encoder's top priority.
    always_comb begin
        enc_in = '0;
        for (int k = 0; k < NREQ; k++) begin
            enc_in[NREQ-1-k] = req[ptr_q + IDX_W'(k)];
        end
        winner = ptr_q + (IDX_W'(NREQ-1) - enc_idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        enc_in = req;
        winner = enc_idx;
    end
`endif

    prio_enc8 u_enc (
        .req_i (enc_in),
        .idx_o (enc_idx),
        .vld_o (enc_vld)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        to_d    = 1'b0;
`ifdef PRIO_ARB8_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (enc_vld) begin
                    state_d = OWN;
                    gnt_d   = idx2onehot(winner);
                    idx_d   = winner;
                    hold_d  = '0;
`ifdef PRIO_ARB8_RR_EN
                    ptr_d   = winner + IDX_W'(1);
`endif
                end else begin
                    gnt_d = '0;
                    idx_d = '0;
                end
            end
            OWN: begin
                // Release by the owner takes precedence over expiry.
                if (!req[idx_q] || (hold_q == HOLD_LAST)) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    idx_d   = '0;
                    hold_d  = '0;
                    to_d    = req[idx_q];
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                idx_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            to_q    <= to_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign gnt_vld = |gnt_q;
    assign timeout = to_q;

endmodule

`default_nettype wire

// File: tb/tb_prio_arb8.sv
// ============================================================================
// Module  : tb_prio_arb8
// Brief   : Randomized self-checking bench for prio_arb8 against a cycle model.
//           Honours PRIO_ARB8_RR_EN in the same way as the design.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prio_arb8;

    localparam int MH = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: owner number (-1 when idle), cycles owned so far.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    bit m_to    = 1'b0;

    prio_arb8 #(.MAX_HOLD(MH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [7:0] r);
`ifdef PRIO_ARB8_RR_EN
        for (int k = 0; k < 8; k++) begin
            if (r[(m_ptr + k) % 8]) return (m_ptr + k) % 8;
        end
`else
        for (int i = 7; i >= 0; i--) begin
            if (r[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_ptr   = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_edge(input logic [7:0] r);
        int w;
        m_to = 1'b0;
        if (m_owner < 0) begin
            w = pick(r);
            if (w >= 0) begin
                m_owner = w;
                m_held  = 1;
                m_ptr   = (w + 1) % 8;
            end
        end else if (!r[m_owner]) begin
            m_owner = -1;
        end else if (m_held == MH) begin
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_held++;
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] eg;
        eg = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
        check({tag, ".gnt"},     32'(gnt),     32'(eg));
        check({tag, ".gnt_idx"}, 32'(gnt_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        check({tag, ".gnt_vld"}, 32'(gnt_vld), (m_owner < 0) ? 32'd0 : 32'd1);
        check({tag, ".timeout"}, 32'(timeout), 32'(m_to));
    endtask

    task automatic step(input logic [7:0] v, input string tag);
        @(negedge clk);
        req = v;
        @(posedge clk);
        model_edge(v);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [7:0] rv;
        req   = 8'h00;
        rst_n = 1'b0;
        model_reset();
        #3;
        check_all("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) step(8'h00, "idle");

        step(8'h44, "two_req");
        step(8'h44, "two_req_hold");
        step(8'h04, "owner_drop");
        step(8'h04, "regrant");
        step(8'h00, "release");
        step(8'h00, "bubble");

        for (int i = 0; i < 14; i++) step(8'h01, "expiry");
        step(8'h00, "expiry_end");
        step(8'h00, "expiry_idle");

        for (int i = 0; i < 40; i++) step(8'hFF, "all_req");
        step(8'h00, "all_end");
        step(8'h00, "all_idle");

        // Mid-grant reset must clear outputs without waiting for a clock edge.
        step(8'h10, "pre_rst");
        step(8'h10, "pre_rst_hold");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        step(8'h10, "post_rst");

        rv = 8'h00;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(3) == 0) begin
                rv = ($urandom_range(5) == 0) ? 8'h00 : 8'($urandom);
            end else if ($urandom_range(7) == 0) begin
                rv = rv ^ (8'h01 << $urandom_range(7));
            end
            step(rv, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
